// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU and debug ports.
// Each grant holds the memory strobe for LATENCY cycles, then pulses the owner's Ack for one cycle.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates on Pri when both ports ask
// ACCESS | strobe asserted toward memory; counter counts down to zero
// RESP   | Ack to the owning port; priority flips to the other port
module dm_port_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CpuReq,
  input  logic        CpuWrite,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  output logic        CpuAck,
  output logic [31:0] CpuRData,
  output logic        CpuStall,
  input  logic        DbgReq,
  input  logic        DbgWrite,
  input  logic [31:0] DbgAddr,
  input  logic [31:0] DbgWData,
  output logic        DbgAck,
  output logic [31:0] DbgRData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemRData,
  output logic        Owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic        pri_q, pri_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        grant_dbg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pri_q       <= pri_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pri_d       = pri_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_dbg   = 1'b0;
    case (state_q)
      IDLE: begin
        if (CpuReq || DbgReq) begin
          // Pri = 0 favours the CPU on a tie, Pri = 1 favours debug
          grant_dbg = DbgReq && (!CpuReq || pri_q);
          owner_d   = grant_dbg;
          wr_d      = grant_dbg ? DbgWrite : CpuWrite;
          addr_d    = grant_dbg ? DbgAddr  : CpuAddr;
          wdata_d   = grant_dbg ? DbgWData : CpuWData;
          cnt_d     = CNT_INIT;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            if (owner_q) dbg_rdata_d = MemRData;
            else         cpu_rdata_d = MemRData;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        pri_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and Acks decode straight from state so a reset removes them at once.
  assign MemRead  = (state_q == ACCESS) && !wr_q;
  assign MemWrite = (state_q == ACCESS) &&  wr_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign CpuAck   = (state_q == RESP) && !owner_q;
  assign DbgAck   = (state_q == RESP) &&  owner_q;
  assign CpuRData = cpu_rdata_q;
  assign DbgRData = dbg_rdata_q;
  assign CpuStall = CpuReq && !CpuAck;
  assign Owner    = owner_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: four arbiter instances with LATENCY 1..4, each with its own small memory.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic [3:0]  rst, cpu_req, cpu_write, dbg_req, dbg_write;
  logic [31:0] cpu_addr [4];
  logic [31:0] cpu_wdata [4];
  logic [31:0] dbg_addr [4];
  logic [31:0] dbg_wdata [4];
  logic [3:0]  cpu_ack, cpu_stall, dbg_ack, mem_write, mem_read, owner;
  logic [31:0] cpu_rdata [4];
  logic [31:0] dbg_rdata [4];
  logic [31:0] mem_addr [4];
  logic [31:0] mem_wdata [4];
  logic [31:0] mem_rdata [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] mem [32];

    dm_port_arbiter #(.LATENCY(g + 1)) u_dut (
      .Clk(clk), .Rst(rst[g]),
      .CpuReq(cpu_req[g]), .CpuWrite(cpu_write[g]), .CpuAddr(cpu_addr[g]), .CpuWData(cpu_wdata[g]),
      .CpuAck(cpu_ack[g]), .CpuRData(cpu_rdata[g]), .CpuStall(cpu_stall[g]),
      .DbgReq(dbg_req[g]), .DbgWrite(dbg_write[g]), .DbgAddr(dbg_addr[g]), .DbgWData(dbg_wdata[g]),
      .DbgAck(dbg_ack[g]), .DbgRData(dbg_rdata[g]),
      .MemAddr(mem_addr[g]), .MemWData(mem_wdata[g]), .MemWrite(mem_write[g]), .MemRead(mem_read[g]),
      .MemRData(mem_rdata[g]), .Owner(owner[g])
    );

    assign mem_rdata[g] = mem[mem_addr[g][6:2]];

    // 0x10 holds 0xDEADBEEF, every other word 0xA5A5_00ii
    always_ff @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        for (int k = 0; k < 32; k++) mem[k] <= (k == 4) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(k));
      end else if (mem_write[g]) begin
        mem[mem_addr[g][6:2]] <= mem_wdata[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete single-port transaction; returns one cycle after the Ack cycle.
  task automatic xact(input int i, input bit dbg, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int lat);
    if (dbg) begin
      dbg_write[i] = wr; dbg_addr[i] = a; dbg_wdata[i] = d; dbg_req[i] = 1'b1;
    end else begin
      cpu_write[i] = wr; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_req[i] = 1'b1;
    end
    repeat (lat) tick();
    tick();
    chk("xact_ack", dbg ? dbg_ack[i] : cpu_ack[i], 32'd1);
    chk("xact_other_ack", dbg ? cpu_ack[i] : dbg_ack[i], 32'd0);
    cpu_req[i] = 1'b0;
    dbg_req[i] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 4'hF; cpu_req = '0; cpu_write = '0; dbg_req = '0; dbg_write = '0;
    for (int i = 0; i < 4; i++) begin
      cpu_addr[i] = '0; cpu_wdata[i] = '0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
    end
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mem_read",  mem_read[i],  0);
      chk("rst_mem_write", mem_write[i], 0);
      chk("rst_mem_addr",  mem_addr[i],  0);
      chk("rst_mem_wdata", mem_wdata[i], 0);
      chk("rst_cpu_ack",   cpu_ack[i],   0);
      chk("rst_dbg_ack",   dbg_ack[i],   0);
      chk("rst_cpu_rdata", cpu_rdata[i], 0);
      chk("rst_dbg_rdata", dbg_rdata[i], 0);
      chk("rst_owner",     owner[i],     0);
      chk("rst_stall",     cpu_stall[i], 0);
    end
    tick();
    rst = 4'h0;
    tick();

    // LATENCY=1 CPU read of 0x10
    cpu_write[0] = 1'b0; cpu_addr[0] = 32'h10; cpu_req[0] = 1'b1;
    #1;
    chk("t1_c0_stall", cpu_stall[0], 1);
    chk("t1_c0_read",  mem_read[0],  0);
    tick();
    chk("t1_c1_read",  mem_read[0],  1);
    chk("t1_c1_addr",  mem_addr[0],  32'h10);
    chk("t1_c1_stall", cpu_stall[0], 1);
    chk("t1_c1_ack",   cpu_ack[0],   0);
    tick();
    chk("t1_c2_ack",   cpu_ack[0],   1);
    chk("t1_c2_rdata", cpu_rdata[0], 32'hDEADBEEF);
    chk("t1_c2_read",  mem_read[0],  0);
    chk("t1_c2_stall", cpu_stall[0], 0);
    cpu_req[0] = 1'b0;
    tick();
    chk("t1_c3_ack",   cpu_ack[0],   0);

    // LATENCY=3 debug write, then CPU read-back
    dbg_write[2] = 1'b1; dbg_addr[2] = 32'h40; dbg_wdata[2] = 32'h12345678; dbg_req[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("t2_wr_strobe", mem_write[2], 1);
      chk("t2_wr_data",   mem_wdata[2], 32'h12345678);
      chk("t2_wr_addr",   mem_addr[2],  32'h40);
      chk("t2_wr_noack",  dbg_ack[2],   0);
    end
    tick();
    chk("t2_c4_ack",    dbg_ack[2],   1);
    chk("t2_c4_cpuack", cpu_ack[2],   0);
    chk("t2_c4_strobe", mem_write[2], 0);
    chk("t2_c4_owner",  owner[2],     1);
    dbg_req[2] = 1'b0;
    tick();
    cpu_write[2] = 1'b0; cpu_addr[2] = 32'h40; cpu_req[2] = 1'b1;
    repeat (3) tick();
    tick();
    chk("t2_rb_ack",   cpu_ack[2],   1);
    chk("t2_rb_rdata", cpu_rdata[2], 32'h12345678);
    cpu_req[2] = 1'b0;
    tick();

    // Continuous contention from reset, LATENCY=1
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    cpu_write[0] = 1'b0; cpu_addr[0] = 32'h10; cpu_req[0] = 1'b1;
    dbg_write[0] = 1'b0; dbg_addr[0] = 32'h14; dbg_req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_owner", owner[0], 32'(k % 2));
      tick();
      chk("t3_cpu_ack", cpu_ack[0], 32'((k + 1) % 2));
      chk("t3_dbg_ack", dbg_ack[0], 32'(k % 2));
      if (k % 2 == 0) chk("t3_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
      else            chk("t3_dbg_rdata", dbg_rdata[0], 32'hA5A50005);
      if (k == 3) begin
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
      end
      tick();
    end

    // LATENCY=2 read with the request withdrawn in cycle 1
    cpu_write[1] = 1'b0; cpu_addr[1] = 32'h10; cpu_req[1] = 1'b1;
    tick();
    chk("t4_c1_read", mem_read[1], 1);
    cpu_req[1] = 1'b0;
    tick();
    chk("t4_c2_read", mem_read[1], 1);
    tick();
    chk("t4_c3_ack",   cpu_ack[1],   1);
    chk("t4_c3_rdata", cpu_rdata[1], 32'hDEADBEEF);
    chk("t4_c3_read",  mem_read[1],  0);
    tick();
    chk("t4_c4_read", mem_read[1], 0);
    chk("t4_c4_ack",  cpu_ack[1],  0);
    tick();
    chk("t4_c5_read", mem_read[1], 0);
    chk("t4_c5_ack",  cpu_ack[1],  0);

    // LATENCY=4: CPU read leaves Pri=1, then reset lands mid debug read
    xact(3, 1'b0, 1'b0, 32'h10, 32'h0, 4);
    dbg_write[3] = 1'b0; dbg_addr[3] = 32'h14; dbg_req[3] = 1'b1;
    tick();
    chk("t5_c1_owner", owner[3],    1);
    chk("t5_c1_read",  mem_read[3], 1);
    tick();
    chk("t5_c2_read",  mem_read[3], 1);
    rst[3] = 1'b1;
    #1;
    chk("t5_rst_read",   mem_read[3], 0);
    chk("t5_rst_dbgack", dbg_ack[3],  0);
    chk("t5_rst_cpuack", cpu_ack[3],  0);
    chk("t5_rst_owner",  owner[3],    0);
    chk("t5_rst_addr",   mem_addr[3], 0);
    tick();
    rst[3] = 1'b0;
    cpu_write[3] = 1'b0; cpu_addr[3] = 32'h10; cpu_req[3] = 1'b1;
    tick();
    chk("t5_tie_owner", owner[3],    0);
    chk("t5_tie_addr",  mem_addr[3], 32'h10);
    repeat (3) tick();
    tick();
    chk("t5_cpu_ack", cpu_ack[3], 1);
    cpu_req[3] = 1'b0;
    tick();
    tick();
    chk("t5_dbg_owner", owner[3],    1);
    chk("t5_dbg_addr",  mem_addr[3], 32'h14);
    repeat (3) tick();
    tick();
    chk("t5_dbg_ack",   dbg_ack[3],   1);
    chk("t5_dbg_cpu",   cpu_ack[3],   0);
    chk("t5_dbg_rdata", dbg_rdata[3], 32'hA5A50005);
    dbg_req[3] = 1'b0;
    tick();

    // Writes leave both read-data registers untouched
    xact(0, 1'b1, 1'b1, 32'h20, 32'hAAAA0000, 1);
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);
    chk("t6_dbg_rdata", dbg_rdata[0], 32'hAAAA0000);
    chk("t6_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
    xact(0, 1'b0, 1'b1, 32'h24, 32'h00000055, 1);
    chk("t6_dbg_keep", dbg_rdata[0], 32'hAAAA0000);
    chk("t6_cpu_keep", cpu_rdata[0], 32'hDEADBEEF);
    xact(0, 1'b0, 1'b0, 32'h24, 32'h0, 1);
    chk("t6_cpu_rb", cpu_rdata[0], 32'h00000055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
